// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives run/divisor controls; the slave returns the divided clock and status.
interface clk_div_prog_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             en;
  logic [WIDTH-1:0] div;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             cfg_err;

  modport master (
    output en, div, div_load,
    input  clk_out, tick, div_active, cfg_err
  );

  modport slave (
    input  en, div, div_load,
    output clk_out, tick, div_active, cfg_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with glitch-free divisor changes at period boundaries.
// Odd divisors use a negedge-retimed copy of the high phase to add the extra half cycle.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_prog_if.slave bus
);
  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             start;
  logic             last;
  logic             div_small;

  assign last      = (cnt_q == act_q - WIDTH'(1));
  assign div_small = (bus.div < MinDiv);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    tick_d     = 1'b0;
    start      = 1'b0;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cfg_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          start   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (last) begin
          if (bus.en) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
            pos_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          // High phase covers cnt 0..D/2-1; odd D gets its extra half from neg_q.
          pos_d = (cnt_d < (act_q >> 1));
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      cnt_d  = '0;
      pos_d  = 1'b1;
      tick_d = 1'b1;
      if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end

    // A load on the boundary edge lands in pending after the old pending was consumed.
    if (bus.div_load) begin
      pend_d     = div_small ? MinDiv : bus.div;
      pend_vld_d = 1'b1;
      cfg_err_d  = div_small;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      act_q      <= DefDiv;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Half-cycle stretch of the high phase, only for odd divisors.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & act_q[0];
    end
  end

  assign bus.clk_out    = pos_q | neg_q;
  assign bus.tick       = tick_q;
  assign bus.div_active = act_q;
  assign bus.cfg_err    = cfg_err_q;
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: width of divisor bus and internal counter.
REQ-002 Parameter DEFAULT_DIV, default 5: divisor active out of reset; SHALL be in 2..2^WIDTH-1.
REQ-003 clk  input  1  source clock; the block SHALL use both edges.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run enable, sampled on posedge clk.
REQ-006 div  input  WIDTH  requested divisor D.
REQ-007 div_load  input  1  one-cycle strobe; captures div on posedge clk.
REQ-008 clk_out  output  1  divided clock, 50% duty for every D >= 2.
REQ-009 tick  output  1  one-clk-cycle pulse marking the start of each clk_out period.
REQ-010 div_active  output  WIDTH  divisor currently in effect.
REQ-011 cfg_err  output  1  one-cycle pulse when a loaded div < 2 was clamped.

Function
REQ-012 Counter cnt (WIDTH bits) SHALL count 0..D-1 on posedge clk and wrap to 0; period boundary = posedge where cnt wraps to 0, or the first posedge of run after idle.
REQ-013 Even D: clk_out SHALL be high for cnt 0..D/2-1 and low for cnt D/2..D-1, with transitions on posedge clk only.
REQ-014 Odd D: clk_out SHALL rise on the posedge entering cnt 0 and fall on the negedge inside the cycle where cnt = (D-1)/2, giving high time D/2 clk periods.
REQ-015 Odd-D realisation: posedge flag OR-ed with a negedge-retimed copy; the negedge path SHALL be disabled for even D.
REQ-016 clk_out SHALL be driven only from flops or OR of flops; no input-to-clk_out combinational path; no runt pulses at any boundary.
REQ-017 tick SHALL assert for exactly the posedge cycle in which cnt = 0 while running.
REQ-018 On div_load, div SHALL be captured into a pending register; a later div_load before the boundary SHALL overwrite it (last write wins).
REQ-019 Pending divisor SHALL become div_active at the next period boundary, never mid-period; div_active and the shape of that period SHALL change together.
REQ-020 div < 2 on load SHALL be clamped to 2 and cfg_err pulsed one cycle after the load strobe.
REQ-021 div_load coincident with a boundary SHALL take effect at the following boundary, not the current one.
REQ-022 en falling mid-period SHALL let the current period finish; at the boundary the block SHALL go idle: cnt = 0, clk_out = 0, tick = 0.
REQ-023 en rising while idle SHALL start a period on the next posedge, applying any pending divisor first.
REQ-024 en toggling low then high within one period SHALL not shorten or extend that period.

Reset
REQ-025 On rst_n low, immediately: cnt = 0, clk_out = 0, tick = 0, cfg_err = 0, div_active = DEFAULT_DIV, pending cleared, negedge flop = 0.
REQ-026 After rst_n deasserts, the first period SHALL start on the first posedge with en = 1, with no partial pulse.
REQ-027 rst_n asserted mid-period SHALL force clk_out low within the same clk half-cycle, discarding the period.

Verification
REQ-028 Reset, en = 1, D = 5 default -> clk_out period 5 clk, high 2.5 clk, rising on posedge, tick every 5 cycles, div_active = 5.
REQ-029 div = 4 loaded mid-period of D = 5 -> current 5-cycle period completes, then 4-cycle periods with high 2 clk, div_active = 4 from that boundary.
REQ-030 div = 1 loaded -> cfg_err pulse, div_active = 2, clk_out = clk/2, 1 clk high.
REQ-031 div = 7 loaded then div = 6 within the same period -> only 6 applied at the boundary; no 7-cycle period.
REQ-032 en dropped at cnt = 2 of D = 5 -> period completes, clk_out stays 0, tick stops; en raised -> clean restart on next posedge.
REQ-033 rst_n pulsed at cnt = 3, clk_out high -> clk_out low at once; div_active = DEFAULT_DIV after release.
